decoder_7s: RTL
===============

DECODER_7S -- requirements
Module: decoder_7s

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning the number of consecutive identical enabled samples needed to accept a pattern; legal range 1..255.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port seg_in, input, 7 bits: active-low segment pattern, bit0=a through bit6=g.
REQ-005 SHALL have port sample_en, input, 1 bit: when high, seg_in is sampled this edge.
REQ-006 SHALL have port out_ready, input, 1 bit: consumer accepts digit when high with out_valid.
REQ-007 SHALL have port hist_clear, input, 1 bit: synchronous clear of the digit history.
REQ-008 SHALL have port digit, output, 4 bits: the decoded hex value.
REQ-009 SHALL have port out_valid, output, 1 bit: digit holds an unconsumed value.
REQ-010 SHALL have port seg_error, output, 1 bit: one-cycle pulse on an accepted, undecodable pattern.
REQ-011 SHALL have port overflow, output, 1 bit: one-cycle pulse when an unconsumed digit is overwritten.
REQ-012 SHALL have port hist, output, 16 bits: the last four decoded digits, newest in [3:0].
REQ-013 SHALL have port hist_count, output, 3 bits: number of valid history digits, 0..4.

Function
REQ-014 SHALL decode patterns 0-F: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
REQ-015 SHALL treat 1111111 as blank: accepted normally, but no digit and no error produced.
REQ-016 SHALL treat any other accepted pattern as undecodable: seg_error pulses for 1 cycle; digit, out_valid and hist are unchanged.
REQ-017 SHALL implement two states, TRACK and HOLD, with a registered last sample seg_q and an 8-bit count cnt.
REQ-018 SHALL leave state, seg_q and cnt unchanged when sample_en=0.
REQ-019 In HOLD with sample_en=1 and seg_in!=seg_q, SHALL load seg_q<=seg_in and cnt<=1, then go to TRACK; if STABLE_CYCLES=1 it SHALL accept immediately and stay in HOLD.
REQ-020 In HOLD with seg_in==seg_q, SHALL do nothing, so a held pattern is never re-emitted.
REQ-021 In TRACK with sample_en=1 and seg_in==seg_q, SHALL increment cnt; when the new count equals STABLE_CYCLES it SHALL accept and go to HOLD.
REQ-022 In TRACK with sample_en=1 and seg_in!=seg_q, SHALL load seg_q<=seg_in and cnt<=1, staying in TRACK unless STABLE_CYCLES=1.
REQ-023 Acceptance latency: out_valid SHALL be visible after the STABLE_CYCLES-th consecutive matching enabled edge, counted from the first edge that samples the new pattern.
REQ-024 On a decodable accept, SHALL set digit<=value and out_valid<=1.
REQ-025 If out_valid=1 and out_ready=0 at a decodable accept, SHALL overwrite digit (latest wins) and pulse overflow.
REQ-026 When out_valid & out_ready with no accept in the same cycle, SHALL clear out_valid next cycle.
REQ-027 On a simultaneous accept and consume, SHALL load the new digit, keep out_valid=1, and not pulse overflow.
REQ-028 On a decodable accept, SHALL set hist<={hist[11:0],value} and hist_count<=min(hist_count+1,4), independent of the handshake.
REQ-029 hist_clear SHALL zero hist and hist_count; if it coincides with an accept, the clear SHALL win for history while digit/out_valid still update.
REQ-030 The same digit SHALL only be re-emitted after an intervening different pattern (blank included) has been accepted.

Reset
REQ-031 reset=1 SHALL force state=HOLD, seg_q=1111111, cnt=0, digit=0, out_valid=0, seg_error=0, overflow=0, hist=0, hist_count=0, with priority over all inputs.
REQ-032 Reset mid-TRACK SHALL discard partial counts; out_valid SHALL not assert from pre-reset samples.

Verification
REQ-033 STABLE_CYCLES=4, sample_en=1, seg_in=0110000 held 4 edges -> after 4th edge digit=3, out_valid=1, hist=0x0003, hist_count=1; further holding produces no re-emission.
REQ-034 seg_in 0010010 for 3 edges, then 0000010 for 4 edges -> only digit=6 emitted; no 5.
REQ-035 Emit 1, then 2 with out_ready=0 throughout -> overflow pulses once; digit=2; out_valid stays 1; raising out_ready for 1 cycle -> out_valid=0.
REQ-036 seg_in=1110111 stable 4 edges -> seg_error 1-cycle pulse; digit, out_valid and hist unchanged; then 1111111 stable -> no pulses.
REQ-037 Emit digits 1,2,3,4,5 separated by blanks -> hist=0x2345, hist_count=4; hist_clear together with a 6 accept -> hist=0, hist_count=0, digit=6, out_valid=1.
REQ-038 reset asserted after 2 matching samples of 1111000 -> all outputs at reset values; 4 further samples after reset are needed before digit=7 appears.

Source files
------------

// File: rtl/decoder_7s.sv
// rtl/decoder_7s.sv - debounced seven-segment pattern decoder with handshake and digit history
//
// Purpose: samples an active-low 7-segment pattern, accepts it once it has been
// seen on STABLE_CYCLES consecutive enabled edges, decodes it to a hex digit and
// presents it through a valid/ready handshake, keeping a four-digit history.
//
// Ports:
//   clk        in   1  clock, all state updates on the rising edge
//   reset      in   1  synchronous active-high reset
//   seg_in     in   7  active-low segments, bit0=a .. bit6=g
//   sample_en  in   1  seg_in is sampled on this edge when high
//   out_ready  in   1  consumer takes digit when high together with out_valid
//   hist_clear in   1  synchronous clear of the digit history
//   digit      out  4  last decoded hex value
//   out_valid  out  1  digit holds an unconsumed value
//   seg_error  out  1  one-cycle pulse on an accepted undecodable pattern
//   overflow   out  1  one-cycle pulse when an unconsumed digit is overwritten
//   hist       out 16  last four decoded digits, newest in [3:0]
//   hist_count out  3  number of valid history digits, 0..4

module decoder_7s #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  seg_in,
  input  logic        sample_en,
  input  logic        out_ready,
  input  logic        hist_clear,
  output logic [3:0]  digit,
  output logic        out_valid,
  output logic        seg_error,
  output logic        overflow,
  output logic [15:0] hist,
  output logic [2:0]  hist_count
);

  typedef enum logic {
    S_HOLD  = 1'b0,
    S_TRACK = 1'b1
  } state_t;

  localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);
  localparam logic [6:0] BLANK    = 7'b1111111;

  state_t      state_q, state_d;
  logic [6:0]  seg_q, seg_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  cnt_inc;
  logic        accept;

  logic [3:0]  digit_q, digit_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        ovf_q, ovf_d;
  logic [15:0] hist_q, hist_d;
  logic [2:0]  hcnt_q, hcnt_d;

  logic        dec_ok;
  logic [3:0]  dec_val;
  logic        is_blank;

  // Returns {decodable, value}.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'b1000000: decode = {1'b1, 4'h0};
      7'b1111001: decode = {1'b1, 4'h1};
      7'b0100100: decode = {1'b1, 4'h2};
      7'b0110000: decode = {1'b1, 4'h3};
      7'b0011001: decode = {1'b1, 4'h4};
      7'b0010010: decode = {1'b1, 4'h5};
      7'b0000010: decode = {1'b1, 4'h6};
      7'b1111000: decode = {1'b1, 4'h7};
      7'b0000000: decode = {1'b1, 4'h8};
      7'b0010000: decode = {1'b1, 4'h9};
      7'b0001000: decode = {1'b1, 4'hA};
      7'b0000011: decode = {1'b1, 4'hB};
      7'b1000110: decode = {1'b1, 4'hC};
      7'b0100001: decode = {1'b1, 4'hD};
      7'b0000110: decode = {1'b1, 4'hE};
      7'b0001110: decode = {1'b1, 4'hF};
      default:    decode = {1'b0, 4'h0};
    endcase
  endfunction

  assign cnt_inc = cnt_q + 8'd1;

  // State register (all registers share the synchronous reset).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_HOLD;
      seg_q   <= BLANK;
      cnt_q   <= 8'd0;
      digit_q <= 4'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      hist_q  <= 16'd0;
      hcnt_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      hist_q  <= hist_d;
      hcnt_q  <= hcnt_d;
    end
  end

  // Next-state logic. A changed pattern always restarts the count at 1,
  // whichever state we are in; a repeated pattern only counts in TRACK, so a
  // held pattern in HOLD is never accepted twice.
  always_comb begin
    state_d = state_q;
    seg_d   = seg_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    if (sample_en) begin
      if (seg_in != seg_q) begin
        seg_d = seg_in;
        cnt_d = 8'd1;
        if (STABLE_C == 8'd1) begin
          accept  = 1'b1;
          state_d = S_HOLD;
        end else begin
          state_d = S_TRACK;
        end
      end else if (state_q == S_TRACK) begin
        cnt_d = cnt_inc;
        if (cnt_inc == STABLE_C) begin
          accept  = 1'b1;
          state_d = S_HOLD;
        end
      end
    end
  end

  // Output logic. On an accept seg_in is the accepted pattern.
  always_comb begin
    {dec_ok, dec_val} = decode(seg_in);
    is_blank = (seg_in == BLANK);

    digit_d = digit_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    ovf_d   = 1'b0;
    hist_d  = hist_q;
    hcnt_d  = hcnt_q;

    if (accept && dec_ok) begin
      digit_d = dec_val;
      valid_d = 1'b1;
      ovf_d   = valid_q & ~out_ready;
      hist_d  = {hist_q[11:0], dec_val};
      hcnt_d  = (hcnt_q == 3'd4) ? 3'd4 : hcnt_q + 3'd1;
    end else begin
      err_d = accept & ~is_blank;
      if (valid_q && out_ready) begin
        valid_d = 1'b0;
      end
    end

    // Clear wins over a same-cycle history push.
    if (hist_clear) begin
      hist_d = 16'd0;
      hcnt_d = 3'd0;
    end
  end

  assign digit      = digit_q;
  assign out_valid  = valid_q;
  assign seg_error  = err_q;
  assign overflow   = ovf_q;
  assign hist       = hist_q;
  assign hist_count = hcnt_q;

endmodule
